// File: rtl/pc_unit_pkg.sv
// Shared FSM state and exception-cause encodings for the PC unit.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2
  } pc_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_EXT      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: exception > eret > stall > jump > branch > sequential,
// with misaligned jump/branch targets converted into an exception.
module pc_next_mux
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_0080),
  parameter int               ALIGN_BITS = 2
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_seq,
  input  logic [WIDTH-1:0] epc,
  input  logic             in_handler,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] next_pc,
  output logic             take_exc,
  output logic [1:0]       cause,
  output logic             redirect
);

  // Mask form keeps ALIGN_BITS=0 legal: the mask collapses to zero.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  logic [WIDTH-1:0] target;
  logic             misaligned;

  assign target     = jump ? jump_target : branch_target;
  assign misaligned = |(target & ALIGN_MASK);

  always_comb begin
    next_pc  = pc_seq;
    take_exc = 1'b0;
    cause    = CAUSE_NONE;
    redirect = 1'b0;
    if (exc_req) begin
      next_pc  = EXC_VEC;
      take_exc = 1'b1;
      cause    = CAUSE_EXT;
      redirect = 1'b1;
    end else if (eret && in_handler) begin
      next_pc  = epc;
      redirect = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end else if (jump || branch_taken) begin
      redirect = 1'b1;
      if (misaligned) begin
        next_pc  = EXC_VEC;
        take_exc = 1'b1;
        cause    = CAUSE_MISALIGN;
      end else begin
        next_pc = target;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// MIPS fetch-stage program counter: holds PC, applies next-PC selection,
// and records EPC/cause on exceptions.
//   state   | meaning
//   BOOT    | first cycle after reset, pc held at reset vector, not yet fetchable
//   RUN     | normal fetch
//   HANDLER | executing exception handler, eret returns to epc
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_0080),
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             pc_valid,
  output logic             flush,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       exc_cause,
  output logic             in_handler
);

  pc_state_e        state, state_next;
  logic [WIDTH-1:0] next_pc;
  logic             take_exc;
  logic             redirect;
  logic [1:0]       cause;
  logic             eret_take;

  assign pc_next_seq = pc + WIDTH'(INC);
  assign in_handler  = (state == HANDLER);
  assign eret_take   = in_handler && eret && !exc_req;

  pc_next_mux #(
    .WIDTH     (WIDTH),
    .EXC_VEC   (EXC_VEC),
    .ALIGN_BITS(ALIGN_BITS)
  ) u_mux (
    .pc           (pc),
    .pc_seq       (pc_next_seq),
    .epc          (epc),
    .in_handler   (in_handler),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .exc_req      (exc_req),
    .eret         (eret),
    .next_pc      (next_pc),
    .take_exc     (take_exc),
    .cause        (cause),
    .redirect     (redirect)
  );

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (take_exc) state_next = HANDLER;
      HANDLER: if (!take_exc && eret_take) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_VEC;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      epc       <= '0;
      exc_cause <= CAUSE_NONE;
    end else begin
      state    <= state_next;
      pc_valid <= 1'b1;
      flush    <= 1'b0;
      // BOOT ignores every control input; PC moves only once fetch is live.
      if (state != BOOT) begin
        pc    <= next_pc;
        flush <= redirect;
        if (take_exc) begin
          epc       <= pc;
          exc_cause <= cause;
        end else if (eret_take) begin
          exc_cause <= CAUSE_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: 32-bit default instance driven from a vector table,
// plus an 8-bit instance for wrap-around and reset-in-handler sequences.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, rst8;
  logic        stall, branch_taken, jump, exc_req, eret;
  logic [31:0] branch_target, jump_target;

  logic [31:0] pc, pc_next_seq, epc;
  logic        pc_valid, flush, in_handler;
  logic [1:0]  exc_cause;

  logic [7:0]  pc8, pc_next_seq8, epc8;
  logic        pc_valid8, flush8, in_handler8;
  logic [1:0]  exc_cause8;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .exc_req(exc_req), .eret(eret), .pc(pc), .pc_next_seq(pc_next_seq),
    .pc_valid(pc_valid), .flush(flush), .epc(epc), .exc_cause(exc_cause),
    .in_handler(in_handler)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'hFC)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target[7:0]), .jump(jump), .jump_target(jump_target[7:0]),
    .exc_req(exc_req), .eret(eret), .pc(pc8), .pc_next_seq(pc_next_seq8),
    .pc_valid(pc_valid8), .flush(flush8), .epc(epc8), .exc_cause(exc_cause8),
    .in_handler(in_handler8)
  );

  typedef struct {
    logic        stall, br, j, exc, eret;
    logic [31:0] bt, jt;
    logic [31:0] e_pc;
    logic        e_flush;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
    logic        e_hnd;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; exc_req = 0; eret = 0;
    branch_target = 0; jump_target = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                              logic x, logic r, logic [31:0] p, logic f, logic [31:0] e,
                              logic [1:0] c, logic h);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt; v.j = j; v.jt = jt; v.exc = x; v.eret = r;
    v.e_pc = p; v.e_flush = f; v.e_epc = e; v.e_cause = c; v.e_hnd = h;
    return v;
  endfunction

  initial begin
    //           stall br bt           j  jt           exc eret pc           fl epc          ca h
    vt[0]  = mk(0, 0, 32'h0,   1, 32'h040, 0, 0, 32'h040, 1, 32'h0,   2'd0, 0);
    vt[1]  = mk(0, 1, 32'h100, 0, 32'h0,   0, 0, 32'h100, 1, 32'h0,   2'd0, 0);
    vt[2]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h0,   2'd0, 0);
    vt[3]  = mk(0, 0, 32'h0,   1, 32'h040, 0, 0, 32'h040, 1, 32'h0,   2'd0, 0);
    vt[4]  = mk(1, 0, 32'h0,   1, 32'h200, 0, 0, 32'h040, 0, 32'h0,   2'd0, 0);
    vt[5]  = mk(0, 0, 32'h0,   1, 32'h200, 0, 0, 32'h200, 1, 32'h0,   2'd0, 0);
    vt[6]  = mk(0, 0, 32'h0,   1, 32'h040, 0, 0, 32'h040, 1, 32'h0,   2'd0, 0);
    vt[7]  = mk(0, 0, 32'h0,   1, 32'h202, 0, 0, 32'h080, 1, 32'h040, 2'd2, 1);
    vt[8]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h084, 0, 32'h040, 2'd2, 1);
    vt[9]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h040, 1, 32'h040, 2'd0, 0);
    vt[10] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h044, 0, 32'h040, 2'd0, 0);
    vt[11] = mk(0, 0, 32'h0,   1, 32'h040, 0, 0, 32'h040, 1, 32'h040, 2'd0, 0);
    vt[12] = mk(1, 1, 32'h100, 0, 32'h0,   1, 0, 32'h080, 1, 32'h040, 2'd1, 1);
    vt[13] = mk(0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h080, 1, 32'h080, 2'd1, 1);
    vt[14] = mk(1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h080, 0, 32'h080, 2'd1, 1);
    vt[15] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h080, 1, 32'h080, 2'd0, 0);
    vt[16] = mk(0, 1, 32'h400, 1, 32'h300, 0, 0, 32'h300, 1, 32'h080, 2'd0, 0);
    vt[17] = mk(0, 1, 32'h101, 0, 32'h0,   0, 0, 32'h080, 1, 32'h300, 2'd2, 1);
    vt[18] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h300, 1, 32'h300, 2'd0, 0);
    vt[19] = mk(0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h304, 0, 32'h300, 2'd0, 0);

    idle();
    rst = 0; rst8 = 0;
    tick(); tick();
    rst = 1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {30'd0, exc_cause}, 32'd0);
    chk("rst_hnd", {31'd0, in_handler}, 32'd0);
    tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    chk("seq_pc4", pc, 32'h4);
    tick();
    chk("seq_pc8", pc, 32'h8);
    chk("seq_next", pc_next_seq, 32'hC);

    for (int i = 0; i < 20; i++) begin
      stall = vt[i].stall; branch_taken = vt[i].br; branch_target = vt[i].bt;
      jump = vt[i].j; jump_target = vt[i].jt; exc_req = vt[i].exc; eret = vt[i].eret;
      tick();
      idle();
      chk($sformatf("v%0d_pc", i), pc, vt[i].e_pc);
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vt[i].e_flush});
      chk($sformatf("v%0d_epc", i), epc, vt[i].e_epc);
      chk($sformatf("v%0d_cause", i), {30'd0, exc_cause}, {30'd0, vt[i].e_cause});
      chk($sformatf("v%0d_hnd", i), {31'd0, in_handler}, {31'd0, vt[i].e_hnd});
      chk($sformatf("v%0d_nseq", i), pc_next_seq, vt[i].e_pc + 32'd4);
    end

    // 8-bit instance: wrap from 0xFC to 0x00, then reset while in HANDLER
    idle();
    rst8 = 0;
    tick();
    rst8 = 1;
    chk("w8_rst_pc", {24'd0, pc8}, 32'hFC);
    chk("w8_rst_valid", {31'd0, pc_valid8}, 32'd0);
    tick();
    chk("w8_boot_pc", {24'd0, pc8}, 32'hFC);
    chk("w8_next_wrap", {24'd0, pc_next_seq8}, 32'h00);
    tick();
    chk("w8_wrap_pc", {24'd0, pc8}, 32'h00);
    chk("w8_wrap_cause", {30'd0, exc_cause8}, 32'd0);
    chk("w8_wrap_hnd", {31'd0, in_handler8}, 32'd0);
    chk("w8_wrap_flush", {31'd0, flush8}, 32'd0);
    exc_req = 1;
    tick();
    exc_req = 0;
    chk("w8_exc_pc", {24'd0, pc8}, 32'h80);
    chk("w8_exc_hnd", {31'd0, in_handler8}, 32'd1);
    chk("w8_exc_cause", {30'd0, exc_cause8}, 32'd1);
    rst8 = 0;
    eret = 1;
    tick();
    eret = 0;
    rst8 = 1;
    chk("w8_hrst_pc", {24'd0, pc8}, 32'hFC);
    chk("w8_hrst_hnd", {31'd0, in_handler8}, 32'd0);
    chk("w8_hrst_valid", {31'd0, pc_valid8}, 32'd0);
    chk("w8_hrst_cause", {30'd0, exc_cause8}, 32'd0);
    chk("w8_hrst_epc", {24'd0, epc8}, 32'h00);
    chk("w8_hrst_flush", {31'd0, flush8}, 32'd0);
    tick();
    chk("w8_reboot_valid", {31'd0, pc_valid8}, 32'd1);
    chk("w8_reboot_pc", {24'd0, pc8}, 32'hFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
